// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous word RAM between the core's
//   instruction-fetch port and its load/store port. Data accesses win,
//   except that after MAX_D_STREAK consecutive data grants while a fetch is
//   waiting, the fetch is granted. Read data returns one cycle after the
//   grant and is routed to the port that issued the read.
//
//   Optional feature macro: ARB_STATS_EN adds saturating 16-bit counters
//   stat_if_wait (cycles fetch waited) and stat_d_cnt (data grants).
//
// Ports
//   CLOCK_50, RESET_N        clock, async active-low reset
//   if_req/if_addr           fetch request (held until if_gnt)
//   if_gnt                   fetch granted this cycle (combinational)
//   if_rvalid/if_rdata       fetch read return, one cycle after if_gnt
//   d_req/d_we/d_addr/
//   d_wdata/d_be             data request (held until d_gnt)
//   d_gnt                    data granted this cycle (combinational)
//   d_rvalid/d_rdata         load return, one cycle after a load grant
//   mem_en/mem_we/mem_be/
//   mem_addr/mem_wdata       RAM command, zeroed when idle
//   mem_rdata                RAM read data, valid the cycle after a read
//
// Read-owner FSM
//   state | meaning
//   NONE  | no read in flight; mem_rdata belongs to nobody
//   IF_RD | mem_rdata this cycle answers a fetch
//   D_RD  | mem_rdata this cycle answers a load
module mem_port_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         stat_if_wait,
  output logic [15:0]         stat_d_cnt
`endif
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    IF_RD = 2'd1,
    D_RD  = 2'd2
  } rd_state_t;

  rd_state_t  state_q, state_d;
  logic [3:0] streak_q, streak_d;

  // Data wins unless fetch is waiting and data already used its streak.
  assign d_gnt  = d_req && (!if_req || (streak_q < STREAK_MAX));
  assign if_gnt = if_req && !d_gnt;
  assign mem_en = if_gnt || d_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_be    = d_we ? d_be : '1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_be    = '1;
      mem_addr  = if_addr;
    end
  end

  // The streak only counts data grants that actually made a fetch wait.
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= NONE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d   = NONE;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    if (if_gnt) begin
      state_d = IF_RD;
    end else if (d_gnt && !d_we) begin
      state_d = D_RD;
    end
    case (state_q)
      IF_RD: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      D_RD: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      stat_if_wait <= '0;
      stat_d_cnt   <= '0;
    end else begin
      if (if_req && !if_gnt && (stat_if_wait != 16'hFFFF)) begin
        stat_if_wait <= stat_if_wait + 16'd1;
      end
      if (d_gnt && (stat_d_cnt != 16'hFFFF)) begin
        stat_d_cnt <= stat_d_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural RAM.
module tb_mem_port_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b1;
  logic        if_req   = 1'b0;
  logic [10:0] if_addr  = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req    = 1'b0;
  logic        d_we     = 1'b0;
  logic [10:0] d_addr   = '0;
  logic [31:0] d_wdata  = '0;
  logic [3:0]  d_be     = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] stat_if_wait, stat_d_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
    ,
    .stat_if_wait (stat_if_wait),
    .stat_d_cnt   (stat_d_cnt)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Behavioural RAM: 16 words, preloaded on the first clock edge.
  logic [31:0] ram [0:15];
  bit          ram_init_done;
  always @(posedge CLOCK_50) begin
    if (!ram_init_done) begin
      ram[0]        <= 32'h0000_0013;
      ram[1]        <= 32'h0000_0000;
      ram[2]        <= 32'h2222_2222;
      ram[3]        <= 32'h3333_3333;
      ram[5]        <= 32'h0050_0293;
      ram_init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) ram[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr[3:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_if_gnt"},    64'(if_gnt),    64'(0));
    chk({tag, "_d_gnt"},     64'(d_gnt),     64'(0));
    chk({tag, "_if_rvalid"}, 64'(if_rvalid), 64'(0));
    chk({tag, "_d_rvalid"},  64'(d_rvalid),  64'(0));
    chk({tag, "_if_rdata"},  64'(if_rdata),  64'(0));
    chk({tag, "_d_rdata"},   64'(d_rdata),   64'(0));
    chk({tag, "_mem_en"},    64'(mem_en),    64'(0));
    chk({tag, "_mem_we"},    64'(mem_we),    64'(0));
    chk({tag, "_mem_be"},    64'(mem_be),    64'(0));
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
  endtask

  task automatic next_cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
  endtask

  bit pri_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit clr_if [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
  bit clr_d  [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [31:0] pipe_exp [4] = '{32'h0000_0013, 32'h0000_AB09, 32'h2222_2222, 32'h3333_3333};

  initial begin
    // Reset state
    #2 RESET_N = 1'b0;
    #10;
    chk_idle_outputs("reset");
`ifdef ARB_STATS_EN
    chk("reset_stat_if_wait", 64'(stat_if_wait), 64'(0));
    chk("reset_stat_d_cnt",   64'(stat_d_cnt),   64'(0));
`endif
    @(negedge CLOCK_50);
    #2 RESET_N = 1'b1;

    // Single fetch
    next_cycle();
    if_req = 1'b1; if_addr = 11'h005;
    @(negedge CLOCK_50);
    chk("fetch_if_gnt",   64'(if_gnt),   64'(1));
    chk("fetch_d_gnt",    64'(d_gnt),    64'(0));
    chk("fetch_mem_en",   64'(mem_en),   64'(1));
    chk("fetch_mem_we",   64'(mem_we),   64'(0));
    chk("fetch_mem_be",   64'(mem_be),   64'(4'hF));
    chk("fetch_mem_addr", 64'(mem_addr), 64'(11'h005));
    next_cycle();
    if_req = 1'b0; if_addr = '0;
    @(negedge CLOCK_50);
    chk("fetch_if_rvalid", 64'(if_rvalid), 64'(1));
    chk("fetch_if_rdata",  64'(if_rdata),  64'(32'h0050_0293));
    chk("fetch_d_rvalid",  64'(d_rvalid),  64'(0));
    chk("fetch_d_rdata",   64'(d_rdata),   64'(0));
    chk("fetch_idle_en",   64'(mem_en),    64'(0));
    chk("fetch_idle_addr", 64'(mem_addr),  64'(0));

    // Store, partial store, then load
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 11'h001; d_wdata = 32'h0000_0009; d_be = 4'hF;
    @(negedge CLOCK_50);
    chk("st_d_gnt",     64'(d_gnt),     64'(1));
    chk("st_if_gnt",    64'(if_gnt),    64'(0));
    chk("st_mem_we",    64'(mem_we),    64'(1));
    chk("st_mem_addr",  64'(mem_addr),  64'(11'h001));
    chk("st_mem_wdata", 64'(mem_wdata), 64'(32'h0000_0009));
    chk("st_mem_be",    64'(mem_be),    64'(4'hF));
    chk("st_if_rvalid", 64'(if_rvalid), 64'(0));
    next_cycle();
    d_wdata = 32'h1111_AB11; d_be = 4'h2;
    @(negedge CLOCK_50);
    chk("st2_mem_be",   64'(mem_be),    64'(4'h2));
    chk("st2_d_rvalid", 64'(d_rvalid),  64'(0));
    next_cycle();
    d_we = 1'b0; d_wdata = '0; d_be = 4'h0;
    @(negedge CLOCK_50);
    chk("ld_d_gnt",     64'(d_gnt),     64'(1));
    chk("ld_mem_we",    64'(mem_we),    64'(0));
    chk("ld_mem_be",    64'(mem_be),    64'(4'hF));
    chk("ld_d_rvalid",  64'(d_rvalid),  64'(0));
    next_cycle();
    d_req = 1'b0; d_addr = '0;
    @(negedge CLOCK_50);
    chk("ld_ret_rvalid",    64'(d_rvalid),  64'(1));
    chk("ld_ret_rdata",     64'(d_rdata),   64'(32'h0000_AB09));
    chk("ld_ret_if_rvalid", 64'(if_rvalid), 64'(0));
    chk("ld_ret_if_rdata",  64'(if_rdata),  64'(0));

    // Priority and streak from a fresh reset
    do_reset();
`ifdef ARB_STATS_EN
    chk("pri_stat_if_wait_0", 64'(stat_if_wait), 64'(0));
    chk("pri_stat_d_cnt_0",   64'(stat_d_cnt),   64'(0));
`endif
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if_req = 1'b1; if_addr = 11'h002;
      d_req = 1'b1; d_we = 1'b0; d_addr = 11'h003; d_be = 4'h0;
      @(negedge CLOCK_50);
      chk($sformatf("pri_d_gnt_%0d", i),    64'(d_gnt),    64'(pri_d[i]));
      chk($sformatf("pri_if_gnt_%0d", i),   64'(if_gnt),   64'(!pri_d[i]));
      chk($sformatf("pri_mem_addr_%0d", i), 64'(mem_addr), pri_d[i] ? 64'(3) : 64'(2));
      if (i > 0) begin
        chk($sformatf("pri_d_rvalid_%0d", i),  64'(d_rvalid),  64'(pri_d[i-1]));
        chk($sformatf("pri_if_rvalid_%0d", i), 64'(if_rvalid), 64'(!pri_d[i-1]));
        chk($sformatf("pri_d_rdata_%0d", i),   64'(d_rdata),
            pri_d[i-1] ? 64'(32'h3333_3333) : 64'(0));
        chk($sformatf("pri_if_rdata_%0d", i),  64'(if_rdata),
            pri_d[i-1] ? 64'(0) : 64'(32'h2222_2222));
      end
    end
    next_cycle();
    if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0;
    @(negedge CLOCK_50);
    chk("pri_last_if_rvalid", 64'(if_rvalid), 64'(1));
    chk("pri_last_if_rdata",  64'(if_rdata),  64'(32'h2222_2222));
    chk("pri_last_d_rvalid",  64'(d_rvalid),  64'(0));
`ifdef ARB_STATS_EN
    chk("pri_stat_d_cnt",   64'(stat_d_cnt),   64'(8));
    chk("pri_stat_if_wait", 64'(stat_if_wait), 64'(8));
`endif

    // Pipelined fetches 0..3
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if_req  = (i < 4);
      if_addr = (i < 4) ? 11'(i) : 11'h000;
      @(negedge CLOCK_50);
      if (i < 4) begin
        chk($sformatf("pipe_if_gnt_%0d", i),   64'(if_gnt),   64'(1));
        chk($sformatf("pipe_mem_addr_%0d", i), 64'(mem_addr), 64'(i));
      end else begin
        chk("pipe_tail_if_gnt", 64'(if_gnt), 64'(0));
      end
      if (i > 0) begin
        chk($sformatf("pipe_if_rvalid_%0d", i), 64'(if_rvalid), 64'(1));
        chk($sformatf("pipe_if_rdata_%0d", i),  64'(if_rdata),  64'(pipe_exp[i-1]));
      end else begin
        chk("pipe_first_if_rvalid", 64'(if_rvalid), 64'(0));
      end
    end
    next_cycle();
    @(negedge CLOCK_50);
    chk("pipe_done_if_rvalid", 64'(if_rvalid), 64'(0));

    // Reset asserted with a load in flight
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 11'h003;
    @(negedge CLOCK_50);
    chk("rst_ld_d_gnt", 64'(d_gnt), 64'(1));
    #1;
    RESET_N = 1'b0;
    d_req = 1'b0; d_addr = '0;
    #1;
    chk_idle_outputs("rst_low");
    next_cycle();
    chk_idle_outputs("rst_low_edge");
`ifdef ARB_STATS_EN
    chk("rst_stat_d_cnt", 64'(stat_d_cnt), 64'(0));
`endif
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    next_cycle();
    chk("rst_rel_d_rvalid_1", 64'(d_rvalid), 64'(0));
    chk("rst_rel_d_rdata_1",  64'(d_rdata),  64'(0));
    next_cycle();
    chk("rst_rel_d_rvalid_2", 64'(d_rvalid), 64'(0));

    // Both requests at reset release, then streak clearing when fetch drops
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 11'h002; if_addr = 11'h000;
    #1 RESET_N = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) next_cycle();
      if_req = clr_if[i];
      #3;
      chk($sformatf("clr_d_gnt_%0d", i),  64'(d_gnt),  64'(clr_d[i]));
      chk($sformatf("clr_if_gnt_%0d", i), 64'(if_gnt), 64'(clr_if[i] && !clr_d[i]));
    end
    next_cycle();
    if_req = 1'b0; d_req = 1'b0; d_addr = '0;
    @(negedge CLOCK_50);
    chk("clr_if_rvalid", 64'(if_rvalid), 64'(1));
    chk("clr_if_rdata",  64'(if_rdata),  64'(32'h0000_0013));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
